// File: rtl/audio_i2s_tx.sv
// I2S transmitter: accepts stereo 16-bit PCM pairs through valid/ready and
// serialises them as 64-slot Philips I2S frames with internally generated BCLK/LRCK.
module audio_i2s_tx #(
    parameter int unsigned BCLK_DIV = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    output logic        sample_ready,
    input  logic        mute,
    output logic        underrun,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_data
);

    localparam logic [9:0] DIV_LAST = 10'(BCLK_DIV - 1);

    // Slot 0 carries the Philips one-bit delay; slots 1..16 are the word MSB-first.
    function automatic logic slot_bit(input logic [4:0] slot, input logic [15:0] word);
        logic [3:0] idx;
        logic       b;
        idx = 4'(5'd16 - slot);
        if ((slot != 5'd0) && (slot <= 5'd16)) begin
            b = word[idx];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    logic [9:0]  div_cnt_q, div_cnt_d;
    logic        bclk_q, bclk_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        lrck_q, lrck_d;
    logic        data_q, data_d;
    logic        underrun_q, underrun_d;
    logic        ready_q, ready_d;
    logic        full_q, full_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic [15:0] frame_l_q, frame_l_d;
    logic [15:0] frame_r_q, frame_r_d;

    logic        tick_s;
    logic        fall_tick_s;
    logic        frame_load_s;
    logic        accept_s;
    logic [5:0]  bit_nxt_s;

    // Next-state logic for divider, slot counter, holding register and frame words.
    always_comb begin
        tick_s       = (div_cnt_q == DIV_LAST);
        fall_tick_s  = tick_s & bclk_q;
        frame_load_s = fall_tick_s & (bit_cnt_q == 6'd63);
        accept_s     = sample_valid & ready_q;
        bit_nxt_s    = bit_cnt_q + 6'd1;

        div_cnt_d  = div_cnt_q;
        bclk_d     = bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        data_d     = data_q;
        underrun_d = 1'b0;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        frame_l_d  = frame_l_q;
        frame_r_d  = frame_r_q;

        if (tick_s) begin
            div_cnt_d = 10'd0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 10'd1;
            bclk_d    = bclk_q;
        end

        // An empty hold at load time repeats the previous pair rather than going silent.
        if (frame_load_s) begin
            underrun_d = ~full_q;
            if (mute) begin
                frame_l_d = 16'h0000;
                frame_r_d = 16'h0000;
            end else if (full_q) begin
                frame_l_d = hold_l_q;
                frame_r_d = hold_r_q;
            end else begin
                frame_l_d = frame_l_q;
                frame_r_d = frame_r_q;
            end
        end else begin
            underrun_d = 1'b0;
        end

        if (accept_s) begin
            hold_l_d = sample_l;
            hold_r_d = sample_r;
            full_d   = 1'b1;
        end else if (frame_load_s) begin
            full_d   = 1'b0;
        end else begin
            full_d   = full_q;
        end

        if (fall_tick_s) begin
            bit_cnt_d = bit_nxt_s;
            lrck_d    = bit_nxt_s[5];
            data_d    = slot_bit(bit_nxt_s[4:0], bit_nxt_s[5] ? frame_r_d : frame_l_d);
        end else begin
            bit_cnt_d = bit_cnt_q;
            lrck_d    = lrck_q;
            data_d    = data_q;
        end

        ready_d = ~full_d;
    end

    // State register with synchronous reset; ready stays low while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= 10'd0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 6'd0;
            lrck_q     <= 1'b0;
            data_q     <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            full_q     <= 1'b0;
            hold_l_q   <= 16'h0000;
            hold_r_q   <= 16'h0000;
            frame_l_q  <= 16'h0000;
            frame_r_q  <= 16'h0000;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrck_q     <= lrck_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            full_q     <= full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
        end
    end

    assign sample_ready = ready_q;
    assign underrun     = underrun_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrck     = lrck_q;
    assign i2s_data     = data_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: a serial monitor decodes whole frames,
// each scenario task pushes the frames it expects and compares them inline.
module tb_audio_i2s_tx;

    localparam int DIV   = 2;
    localparam int FRAME = 128 * DIV;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          zbad;
        int          lbad;
    } frame_t;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_ready;
    logic        mute;
    logic        underrun;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_data;

    frame_t exp_q[$];
    frame_t dec_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc;

    int          rcnt;
    int          slot;
    int          zb;
    int          lb;
    logic [15:0] acc_l;
    logic [15:0] acc_r;
    logic        prev_bclk;
    logic        exp_lr;
    frame_t      mon_f;

    audio_i2s_tx #(.BCLK_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_ready (sample_ready),
        .mute         (mute),
        .underrun     (underrun),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Serial monitor: sample on BCLK rising edges, one decoded frame per 64 slots.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            rcnt = 0; zb = 0; lb = 0; prev_bclk = 1'b0;
            acc_l = 16'h0000; acc_r = 16'h0000;
        end else begin
            if (i2s_bclk === 1'b1 && prev_bclk === 1'b0) begin
                slot   = rcnt % 64;
                exp_lr = (slot >= 32);
                if (i2s_lrck !== exp_lr) lb++;
                if ((slot % 32) >= 1 && (slot % 32) <= 16) begin
                    if (slot < 32) acc_l = {acc_l[14:0], i2s_data};
                    else           acc_r = {acc_r[14:0], i2s_data};
                end else if (i2s_data !== 1'b0) begin
                    zb++;
                end
                if (slot == 63) begin
                    mon_f.l = acc_l; mon_f.r = acc_r; mon_f.zbad = zb; mon_f.lbad = lb;
                    dec_q.push_back(mon_f);
                    zb = 0; lb = 0;
                end
                rcnt++;
            end
            prev_bclk = i2s_bclk;
        end
    end

    function automatic frame_t mk(input logic [15:0] l, input logic [15:0] r);
        frame_t f;
        f.l = l; f.r = r; f.zbad = 0; f.lbad = 0;
        return f;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; sample_valid = 1'b0; mute = 1'b0;
        exp_q.delete(); dec_q.delete();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        sample_l = l; sample_r = r; sample_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME && sample_ready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, output int unders, output int max_w);
        int run;
        unders = 0; max_w = 0; run = 0;
        for (int i = 0; i < 12 * FRAME && dec_q.size() < n; i++) begin
            @(posedge clk); #1;
            if (underrun === 1'b1) begin
                if (run == 0) unders++;
                run++;
                if (run > max_w) max_w = run;
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 8 * FRAME && cyc < target; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        logic       bad;
        frame_t     e, d;
        bad = 1'b0; outs = 5'b0;
        reset = 1'b1; sample_valid = 1'b0; mute = 1'b0; sample_l = 16'h0; sample_r = 16'h0;
        repeat (5) begin
            @(negedge clk);
            if ({i2s_bclk, i2s_lrck, i2s_data, underrun, sample_ready} !== 5'b0) begin
                bad = 1'b1; outs = {i2s_bclk, i2s_lrck, i2s_data, underrun, sample_ready};
            end
        end
        n_cmp++;
        if (bad) begin n_bad++; $display("FAIL reset_outputs: got %b, expected 00000", outs); end
        reset = 1'b0;
        exp_q.push_back(mk(16'h0000, 16'h0000));
        for (int c = 1; c <= 258; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                n_cmp++;
                if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b, expected 1", sample_ready); end
                n_cmp++;
                if (i2s_bclk !== 1'b0) begin n_bad++; $display("FAIL bclk_clk1: got %b, expected 0", i2s_bclk); end
            end else if (c == 2) begin
                n_cmp++;
                if (i2s_bclk !== 1'b1) begin n_bad++; $display("FAIL bclk_first_rise: got %b, expected 1", i2s_bclk); end
            end else if (c == 127 || c == 128) begin
                n_cmp++;
                if (i2s_lrck !== (c == 128)) begin n_bad++; $display("FAIL lrck_clk%0d: got %b, expected %b", c, i2s_lrck, (c == 128)); end
            end else if (c >= 255 && c <= 257) begin
                n_cmp++;
                if (underrun !== (c == 256)) begin n_bad++; $display("FAIL underrun_clk%0d: got %b, expected %b", c, underrun, (c == 256)); end
            end
        end
        n_cmp++;
        if (dec_q.size() < 1) begin
            n_bad++; $display("FAIL reset_frame_count: got %0d frames, expected 1", dec_q.size());
        end else begin
            e = exp_q.pop_front(); d = dec_q.pop_front();
            if (d.l !== e.l || d.r !== e.r || d.zbad != 0 || d.lbad != 0) begin
                n_bad++;
                $display("FAIL reset_frame0: got L=%h R=%h zero_err=%0d lr_err=%0d, expected L=%h R=%h clean", d.l, d.r, d.zbad, d.lbad, e.l, e.r);
            end
        end
    endtask

    task automatic test_single_frame();
        int u, w;
        frame_t e, d;
        do_reset(3);
        exp_q.push_back(mk(16'h0000, 16'h0000));
        send(16'h8001, 16'h7FFE);
        exp_q.push_back(mk(16'h8001, 16'h7FFE));
        wait_frames(2, u, w);
        n_cmp++;
        if (u != 0) begin n_bad++; $display("FAIL single_underrun: got %0d pulses, expected 0", u); end
        n_cmp++;
        if (dec_q.size() < 2) begin n_bad++; $display("FAIL single_count: got %0d frames, expected 2", dec_q.size()); end
        for (int k = 0; k < 2 && dec_q.size() > 0; k++) begin
            e = exp_q.pop_front(); d = dec_q.pop_front(); n_cmp++;
            if (d.l !== e.l || d.r !== e.r || d.zbad != 0 || d.lbad != 0) begin
                n_bad++;
                $display("FAIL single_frame%0d: got L=%h R=%h zero_err=%0d lr_err=%0d, expected L=%h R=%h clean", k, d.l, d.r, d.zbad, d.lbad, e.l, e.r);
            end
        end
    endtask

    task automatic test_underrun();
        int u, w;
        frame_t e, d;
        do_reset(3);
        exp_q.push_back(mk(16'h0000, 16'h0000));
        send(16'h1234, 16'hABCD);
        repeat (3) exp_q.push_back(mk(16'h1234, 16'hABCD));
        wait_frames(4, u, w);
        n_cmp++;
        if (u != 2) begin n_bad++; $display("FAIL underrun_pulses: got %0d, expected 2", u); end
        n_cmp++;
        if (w != 1) begin n_bad++; $display("FAIL underrun_width: got %0d clocks, expected 1", w); end
        n_cmp++;
        if (dec_q.size() < 4) begin n_bad++; $display("FAIL underrun_count: got %0d frames, expected 4", dec_q.size()); end
        for (int k = 0; k < 4 && dec_q.size() > 0; k++) begin
            e = exp_q.pop_front(); d = dec_q.pop_front(); n_cmp++;
            if (d.l !== e.l || d.r !== e.r || d.zbad != 0 || d.lbad != 0) begin
                n_bad++;
                $display("FAIL underrun_frame%0d: got L=%h R=%h zero_err=%0d lr_err=%0d, expected L=%h R=%h clean", k, d.l, d.r, d.zbad, d.lbad, e.l, e.r);
            end
        end
    endtask

    task automatic test_back_to_back();
        int u, w, acc;
        logic pending, rdy, rdy_prev;
        logic [15:0] v;
        frame_t e, d;
        do_reset(3);
        exp_q.push_back(mk(16'h0000, 16'h0000));
        v = 16'h0100; acc = 0; pending = 1'b0; rdy_prev = 1'b1;
        sample_l = v; sample_r = ~v; sample_valid = 1'b1;
        fork
            begin
                for (int g = 0; g < 8 * FRAME && !(acc == 5 && !pending); g++) begin
                    @(negedge clk);
                    rdy = sample_ready;
                    if (pending) begin
                        n_cmp++;
                        if (rdy !== 1'b0) begin n_bad++; $display("FAIL bp_ready_fall%0d: got %b, expected 0", acc, rdy); end
                        pending = 1'b0;
                        v = v + 16'd1; sample_l = v; sample_r = ~v;
                        if (acc == 5) sample_valid = 1'b0;
                    end else if (rdy_prev === 1'b0 && rdy === 1'b1 && acc > 0) begin
                        n_cmp++;
                        if ((cyc % FRAME) != 0) begin n_bad++; $display("FAIL bp_ready_rise: got rise after clock %0d, expected a multiple of %0d", cyc, FRAME); end
                    end
                    if (sample_valid === 1'b1 && rdy === 1'b1) begin
                        exp_q.push_back(mk(v, ~v));
                        acc++; pending = 1'b1;
                    end
                    rdy_prev = rdy;
                end
            end
            begin
                wait_frames(6, u, w);
            end
        join
        n_cmp++;
        if (u != 0) begin n_bad++; $display("FAIL bp_underrun: got %0d pulses, expected 0", u); end
        n_cmp++;
        if (dec_q.size() < 6 || exp_q.size() != 6) begin
            n_bad++; $display("FAIL bp_count: got %0d frames / %0d expected entries, expected 6 / 6", dec_q.size(), exp_q.size());
        end
        for (int k = 0; k < 6 && dec_q.size() > 0 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); d = dec_q.pop_front(); n_cmp++;
            if (d.l !== e.l || d.r !== e.r || d.zbad != 0 || d.lbad != 0) begin
                n_bad++;
                $display("FAIL bp_frame%0d: got L=%h R=%h zero_err=%0d lr_err=%0d, expected L=%h R=%h clean", k, d.l, d.r, d.zbad, d.lbad, e.l, e.r);
            end
        end
    endtask

    task automatic test_mute();
        int u, w;
        frame_t e, d;
        do_reset(3);
        exp_q.push_back(mk(16'h0000, 16'h0000));
        send(16'h7FFF, 16'h0001);
        exp_q.push_back(mk(16'h7FFF, 16'h0001));
        send(16'h7FFF, 16'h0002);
        exp_q.push_back(mk(16'h0000, 16'h0000));
        wait_cyc(2 * FRAME - 2);
        mute = 1'b1;
        wait_cyc(2 * FRAME);
        n_cmp++;
        if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL mute_ready: got %b, expected 1", sample_ready); end
        wait_cyc(2 * FRAME + 2);
        mute = 1'b0;
        send(16'h7FFF, 16'h0003);
        exp_q.push_back(mk(16'h7FFF, 16'h0003));
        wait_frames(4, u, w);
        n_cmp++;
        if (u != 0) begin n_bad++; $display("FAIL mute_underrun: got %0d pulses, expected 0", u); end
        n_cmp++;
        if (dec_q.size() < 4) begin n_bad++; $display("FAIL mute_count: got %0d frames, expected 4", dec_q.size()); end
        for (int k = 0; k < 4 && dec_q.size() > 0; k++) begin
            e = exp_q.pop_front(); d = dec_q.pop_front(); n_cmp++;
            if (d.l !== e.l || d.r !== e.r || d.zbad != 0 || d.lbad != 0) begin
                n_bad++;
                $display("FAIL mute_frame%0d: got L=%h R=%h zero_err=%0d lr_err=%0d, expected L=%h R=%h clean", k, d.l, d.r, d.zbad, d.lbad, e.l, e.r);
            end
        end
    endtask

    task automatic test_reset_mid();
        int u, w;
        logic [4:0] outs;
        frame_t e, d;
        do_reset(3);
        send(16'hAAAA, 16'h5555);
        send(16'hDEAD, 16'hBEEF);
        wait_cyc(FRAME + 40 * 2 * DIV + 2);
        n_cmp++;
        if (dec_q.size() < 1) begin
            n_bad++; $display("FAIL mid_frame0_count: got %0d frames, expected 1", dec_q.size());
        end else begin
            d = dec_q.pop_front();
            if (d.l !== 16'h0000 || d.r !== 16'h0000 || d.zbad != 0 || d.lbad != 0) begin
                n_bad++; $display("FAIL mid_frame0: got L=%h R=%h zero_err=%0d lr_err=%0d, expected L=0000 R=0000 clean", d.l, d.r, d.zbad, d.lbad);
            end
        end
        reset = 1'b1; exp_q.delete(); dec_q.delete();
        @(negedge clk);
        outs = {i2s_bclk, i2s_lrck, i2s_data, underrun, sample_ready};
        n_cmp++;
        if (outs !== 5'b0) begin n_bad++; $display("FAIL mid_reset_outputs: got %b, expected 00000", outs); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(mk(16'h0000, 16'h0000));
        exp_q.push_back(mk(16'h0000, 16'h0000));
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (i2s_bclk !== (c == 2)) begin n_bad++; $display("FAIL mid_bclk_clk%0d: got %b, expected %b", c, i2s_bclk, (c == 2)); end
        end
        wait_frames(2, u, w);
        n_cmp++;
        if (u != 1) begin n_bad++; $display("FAIL mid_underrun: got %0d pulses, expected 1", u); end
        n_cmp++;
        if (dec_q.size() < 2) begin n_bad++; $display("FAIL mid_count: got %0d frames, expected 2", dec_q.size()); end
        for (int k = 0; k < 2 && dec_q.size() > 0; k++) begin
            e = exp_q.pop_front(); d = dec_q.pop_front(); n_cmp++;
            if (d.l !== e.l || d.r !== e.r || d.zbad != 0 || d.lbad != 0) begin
                n_bad++;
                $display("FAIL mid_frame%0d: got L=%h R=%h zero_err=%0d lr_err=%0d, expected L=%h R=%h clean", k, d.l, d.r, d.zbad, d.lbad, e.l, e.r);
            end
        end
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; mute = 1'b0;
        sample_l = 16'h0000; sample_r = 16'h0000;
        test_reset();
        test_single_frame();
        test_underrun();
        test_back_to_back();
        test_mute();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio transmitter that takes stereo signed 16-bit PCM samples from the mixing stage through a valid/ready handshake and drives an external I2S DAC. It generates BCLK and LRCK internally from the system clock. Frames are 64 BCLK periods (32 slots per channel), with 16 data bits MSB-first in Philips I2S alignment. It sits after the mixer/filter chain and is the last block before the board's audio pins.

## Interface
**Parameters**
- BCLK_DIV, 13, system clocks per BCLK half-period; legal range 1..1023.
  - Sample rate = clk / (128·BCLK_DIV).

**Ports**
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  sample_l/sample_r hold a new stereo pair.
- sample_l  in  16  signed left sample.
- sample_r  in  16  signed right sample.
- sample_ready  out  1  holding register empty; a pair is accepted when valid & ready.
- mute  in  1  transmit zeros. Sampled at frame load.
- underrun  out  1  one-clock pulse when a frame loads with the holding register empty.
- i2s_bclk  out  1  bit clock.
- i2s_lrck  out  1  word select; 0 = left, 1 = right.
- i2s_data  out  1  serial data.

## Operation
- **Divider.** div_cnt counts 0..BCLK_DIV-1. On the clock where div_cnt == BCLK_DIV-1, div_cnt returns to 0 and i2s_bclk toggles.
  - A toggle 1→0 is a "fall tick"; all serial state advances only on fall ticks.
- **Slot counter.** bit_cnt is 6 bits and increments on each fall tick, wrapping 63→0.
  - i2s_lrck = registered bit_cnt[5].
  - slot = bit_cnt[4:0].
- **Data per channel half:**
  - slot 0 → 0;
  - slots 1..16 → bits 15..0 of that channel's frame word;
  - slots 17..31 → 0.
  - i2s_data is registered and updated on the fall tick, so it is stable across the BCLK rising edge.
- **Holding register.** One entry plus a full flag.
  - sample_ready = ~full.
  - An accept (valid & ready) writes {sample_l, sample_r} and sets full.
- **Frame load.** Occurs on the fall tick where bit_cnt wraps 63→0.
  - If full: frame_l/frame_r ← holding register and full clears.
  - If empty: frame_l/frame_r keep their previous values and underrun pulses for that one clock.
  - If mute = 1: frame words load 0. The holding register is still consumed when full.
- **Simultaneous accept and frame load, hold full:** the frame takes the old hold content and the hold takes the new pair; full stays 1. This cannot arise with the handshake as specified (ready is 0 while full) and needs no special logic.
- **Simultaneous accept and frame load, hold empty:** there is no bypass. The frame repeats the previous pair, underrun pulses, and the new pair lands in the hold with full = 1.
- **Reset:** all of the following take their reset values on the clock reset is high.
  - i2s_bclk = 0, i2s_lrck = 0, i2s_data = 0, underrun = 0;
  - div_cnt = 0, bit_cnt = 0, full = 0, frame_l = frame_r = 0;
  - sample_ready = 0 while reset is high (inputs ignored), 1 on the first clock after.
  - Reset mid-frame aborts the frame immediately with no completion; the held sample is discarded.

## Timing
- BCLK period = 2·BCLK_DIV clocks. LRCK period = 128·BCLK_DIV clocks. Exactly 32 BCLK periods per LRCK level.
- After reset deasserts:
  - first BCLK rise at clock BCLK_DIV;
  - first fall tick at 2·BCLK_DIV, which takes bit_cnt 0→1.
  - The first frame load happens at the 64th fall tick (bit_cnt 63→0), clock 128·BCLK_DIV. The power-up frame is zeros.
- LRCK changes coincident with the BCLK fall, one BCLK before the MSB. The MSB appears in slot 1.
- Sample-to-pin latency:
  - ≤ 1 frame wait in the hold, plus 1 BCLK to the MSB;
  - the right channel MSB comes 32 BCLKs after the left.
- sample_ready:
  - falls the clock after an accept;
  - rises the clock after the frame load that empties the hold.
- Sustained throughput: one pair per 128·BCLK_DIV clocks. An upstream producer at exactly that rate never underruns once primed.

## Test plan
- **Reset values:** BCLK_DIV=2, hold reset 5 clocks, release.
  - All outputs 0 during reset; sample_ready=1 on the first clock after.
  - First bclk rise 2 clocks after release.
  - lrck first goes high at clock 4·32 = 128.
- **Single frame:** push L=16'h8001, R=16'h7FFE right after reset; capture serial on BCLK rising edges.
  - First frame is all zeros with no underrun (hold full).
  - Second frame decodes L=8001, R=7FFE.
  - Slots 0 and 17..31 are 0.
- **Underrun:** send one pair 16'h1234/16'hABCD, then withhold valid.
  - Next frame load pulses underrun for exactly 1 clock.
  - That frame and all later frames repeat 1234/ABCD.
- **Backpressure:** hold sample_valid=1 with an incrementing value.
  - ready deasserts after each accept and reasserts the clock after each frame load.
  - Decoded stream is consecutive values with no gaps or duplicates.
- **Mute:** with a full stream of 16'h7FFF, set mute=1 across a frame boundary.
  - That frame transmits 0000/0000 and the hold still empties (ready rises).
  - Set mute=0: the next frame carries the following sample.
- **Reset mid-frame:** assert reset at slot 8 of the right half.
  - Outputs go to 0 and bit_cnt restarts.
  - The pending hold sample is never transmitted.
